// File: rtl/calculadora_pkg.sv
// calculadora_pkg: opcodes, FSM state encoding and instruction field layout shared by calculadora_uc.
// CALCULADORA_UC_STEP_EN adds the STEP_WAIT state used by single-step mode.
package calculadora_pkg;
  localparam int INSTR_W = 17;
  localparam int OP_HI = 16;
  localparam int OP_LO = 15;
  localparam int RD_HI = 14;
  localparam int RD_LO = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 0;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
`ifdef CALCULADORA_UC_STEP_EN
    , ST_STEP_WAIT
`endif
  } state_e;
  function automatic logic [1:0] op_of(input logic [INSTR_W-1:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/calculadora_uc_dec.sv
// calculadora_uc_dec: combinational instruction decoder feeding the control unit's datapath outputs.
module calculadora_uc_dec
  import calculadora_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [INSTR_W-1:0] ir,
  output logic               ula_op,
  output logic               wd_sel,
  output logic [W-1:0]       imm,
  output logic               is_halt
);
  always_comb begin
    ula_op = op_of(ir) == OP_SUB;
    wd_sel = op_of(ir) == OP_LDI;
    is_halt = op_of(ir) == OP_HALT;
    imm = W'(ir[RS2_HI:RS2_LO]);
  end
endmodule

// File: rtl/calculadora_uc.sv
// calculadora_uc: fetch/decode/execute/writeback sequencer for the calculadora datapath.
// Define CALCULADORA_UC_STEP_EN to run a single instruction per opera request.
module calculadora_uc
  import calculadora_pkg::*;
#(
  parameter int W   = 32,
  parameter int PCW = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               opera,
  output logic [PCW-1:0]     instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [4:0]         rf_ra1,
  output logic [4:0]         rf_ra2,
  output logic [4:0]         rf_wa,
  output logic               rf_we,
  output logic               ula_op,
  output logic               wd_sel,
  output logic [W-1:0]       imm,
  output logic               busy,
  output logic               done
);
  state_e state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [4:0] ra1_q, ra1_d;
  logic [4:0] ra2_q, ra2_d;
  logic [4:0] wa_q, wa_d;
  logic we_q, we_d;
  logic ula_op_q, ula_op_d;
  logic wd_sel_q, wd_sel_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [W-1:0] imm_q, imm_d;
  logic [W-1:0] dec_imm;
  logic dec_ula_op, dec_wd_sel, dec_halt, act;

  calculadora_uc_dec #(.W(W)) u_dec (
    .ir     (ir_d),
    .ula_op (dec_ula_op),
    .wd_sel (dec_wd_sel),
    .imm    (dec_imm),
    .is_halt(dec_halt)
  );

  always_comb ir_d = (state_q == ST_DECODE) ? instr_data : ir_q;

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    case (state_q)
      ST_IDLE:   state_d = opera ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = dec_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        pc_d = pc_q + PCW'(1);
`ifdef CALCULADORA_UC_STEP_EN
        state_d = ST_STEP_WAIT;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_HALT: begin
        pc_d = '0;
        state_d = ST_IDLE;
      end
`ifdef CALCULADORA_UC_STEP_EN
      ST_STEP_WAIT: state_d = opera ? ST_STEP_WAIT : ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
    act = state_d == ST_EXEC || state_d == ST_WB;
    ra1_d = act ? ir_d[RS1_HI:RS1_LO] : '0;
    ra2_d = act ? ir_d[RS2_HI:RS2_LO] : '0;
    wa_d = act ? ir_d[RD_HI:RD_LO] : '0;
    ula_op_d = act && dec_ula_op;
    wd_sel_d = act && dec_wd_sel;
    imm_d = act ? dec_imm : '0;
    we_d = state_d == ST_WB;
    done_d = state_d == ST_HALT;
`ifdef CALCULADORA_UC_STEP_EN
    busy_d = !(state_d == ST_IDLE || state_d == ST_STEP_WAIT);
`else
    busy_d = state_d != ST_IDLE;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      ra1_q <= '0;
      ra2_q <= '0;
      wa_q <= '0;
      we_q <= 1'b0;
      ula_op_q <= 1'b0;
      wd_sel_q <= 1'b0;
      imm_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ra1_q <= ra1_d;
      ra2_q <= ra2_d;
      wa_q <= wa_d;
      we_q <= we_d;
      ula_op_q <= ula_op_d;
      wd_sel_q <= wd_sel_d;
      imm_q <= imm_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign instr_addr = pc_q;
  assign rf_ra1 = ra1_q;
  assign rf_ra2 = ra2_q;
  assign rf_wa = wa_q;
  assign rf_we = we_q;
  assign ula_op = ula_op_q;
  assign wd_sel = wd_sel_q;
  assign imm = imm_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_calculadora_uc.sv
// tb_calculadora_uc: randomized and directed bench for calculadora_uc against an instruction-level timeline model.
module tb_calculadora_uc;
  localparam int W = 32;
  localparam int PCW = 5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic opera = 1'b0;
  logic [PCW-1:0] instr_addr;
  logic [16:0] instr_data;
  logic [4:0] rf_ra1, rf_ra2, rf_wa;
  logic rf_we, ula_op, wd_sel, busy, done;
  logic [W-1:0] imm;
  logic [16:0] rom [32];
  logic [W-1:0] rf [32];
  int n_checks = 0;
  int n_fail = 0;
  int we_cnt = 0;

  calculadora_uc #(.W(W), .PCW(PCW)) dut (
    .clock(clock), .reset(reset), .opera(opera), .instr_addr(instr_addr), .instr_data(instr_data),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we), .ula_op(ula_op),
    .wd_sel(wd_sel), .imm(imm), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) instr_data <= rom[instr_addr];

  // Stand-in for the calculadora datapath: register file plus add/sub ALU.
  always @(posedge clock) if (rf_we === 1'b1) begin
    rf[rf_wa] <= wd_sel ? imm : (ula_op ? rf[rf_ra1] - rf[rf_ra2] : rf[rf_ra1] + rf[rf_ra2]);
    we_cnt <= we_cnt + 1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [16:0] enc(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  // Model: each instruction expands into its per-cycle output records.
  typedef struct packed {
    logic [4:0] addr;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic we;
    logic ula_op;
    logic wd_sel;
    logic [31:0] imm;
    logic busy;
    logic done;
  } rec_t;
  typedef enum {M_IDLE, M_RUN, M_WAIT} mode_e;
  rec_t q[$];
  rec_t exp_r;
  mode_e mode = M_IDLE;
  logic [4:0] mpc = 5'd0;
  bit mvalid = 1'b0;

  function automatic rec_t idle_rec(input logic [4:0] a);
    rec_t r;
    r = '0;
    r.addr = a;
    return r;
  endfunction

  task automatic push_instr();
    logic [16:0] ins;
    rec_t r;
    ins = rom[mpc];
    r = idle_rec(mpc);
    r.busy = 1'b1;
    q.push_back(r);
    q.push_back(r);
    if (ins[16:15] == 2'b11) begin
      r.done = 1'b1;
      q.push_back(r);
      mpc = 5'd0;
      q.push_back(idle_rec(5'd0));
      mode = M_IDLE;
    end else begin
      r.ra1 = ins[9:5];
      r.ra2 = ins[4:0];
      r.wa = ins[14:10];
      r.ula_op = ins[16:15] == 2'b01;
      r.wd_sel = ins[16:15] == 2'b10;
      r.imm = {27'd0, ins[4:0]};
      q.push_back(r);
      r.we = 1'b1;
      q.push_back(r);
      mpc = mpc + 5'd1;
`ifdef CALCULADORA_UC_STEP_EN
      q.push_back(idle_rec(mpc));
      mode = M_WAIT;
`else
      mode = M_RUN;
`endif
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      mode = M_IDLE;
      mpc = 5'd0;
      exp_r = idle_rec(5'd0);
      mvalid = 1'b1;
    end else if (q.size() > 0) exp_r = q.pop_front();
    else if (mode == M_IDLE && !opera) exp_r = idle_rec(mpc);
    else if (mode == M_WAIT) begin
      if (!opera) mode = M_IDLE;
      exp_r = idle_rec(mpc);
    end else begin
      push_instr();
      exp_r = q.pop_front();
    end
  end

  always @(negedge clock) if (mvalid) begin
    rec_t a;
    a = {instr_addr, rf_ra1, rf_ra2, rf_wa, rf_we, ula_op, wd_sel, imm, busy, done};
    check("cycle_outputs", 64'(a), 64'(exp_r));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    opera = 1'b0;
    cyc(n);
    reset = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) rom[i] = enc(2'd3, 5'd0, 5'd0, 5'd0);
    rom[0] = enc(2'd2, 5'd1, 5'd0, 5'd5);
    rom[1] = enc(2'd2, 5'd2, 5'd0, 5'd3);
    rom[2] = enc(2'd1, 5'd3, 5'd1, 5'd2);
    rom[3] = enc(2'd3, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    logic [31:0] we_mask, done_mask;
    bit done_seen, hold;
    for (int i = 0; i < 32; i++) begin
      rom[i] = '0;
      rf[i] = '0;
    end
    cyc(3);
    reset = 1'b0;
    check("reset_outputs", 64'({rf_we, busy, done, instr_addr}), 64'(0));
    load_prog();
`ifndef CALCULADORA_UC_STEP_EN
    opera = 1'b1;
    cyc();
    opera = 1'b0;
    we_mask = '0;
    done_mask = '0;
    for (int k = 1; k <= 18; k++) begin
      if (rf_we) we_mask[k] = 1'b1;
      if (done) done_mask[k] = 1'b1;
      if (k == 12) check("third_write", 64'({rf_we, rf_wa, rf_ra1, rf_ra2, ula_op, wd_sel}), 64'({1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0}));
      cyc();
    end
    check("we_pulses", 64'(we_mask), 64'(32'h0000_1110));
    check("done_pulse", 64'(done_mask), 64'(32'h0000_8000));
    check("r3_value", 64'(rf[3]), 64'(2));
    check("r1_r2_value", 64'({rf[1], rf[2]}), 64'({32'd5, 32'd3}));
    rom[0] = enc(2'd0, 5'd4, 5'd1, 5'd1);
    rom[1] = enc(2'd3, 5'd0, 5'd0, 5'd0);
    opera = 1'b1;
    cyc();
    opera = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) check("add_wb", 64'({rf_we, wd_sel, ula_op, rf_wa}), 64'({1'b1, 1'b0, 1'b0, 5'd4}));
      cyc();
    end
    check("r4_value", 64'(rf[4]), 64'(10));
    for (int i = 0; i < 32; i++) rom[i] = enc(2'd2, 5'd1, 5'd0, 5'd7);
    opera = 1'b1;
    cyc();
    opera = 1'b0;
    done_seen = 1'b0;
    for (int j = 0; j <= 33; j++) begin
      check("wrap_addr", 64'(instr_addr), 64'(j % 32));
      for (int s = 0; s < 4; s++) begin
        if (done) done_seen = 1'b1;
        cyc();
      end
    end
    check("wrap_no_done", 64'(done_seen), 64'(0));
    do_reset(2);
    rom[0] = enc(2'd3, 5'd0, 5'd0, 5'd0);
    opera = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("hold_halt", 64'({busy, done}), 64'({k % 4 != 0, k % 4 == 3}));
      cyc();
    end
    opera = 1'b0;
    cyc(4);
    rom[0] = enc(2'd2, 5'd5, 5'd0, 5'd9);
    opera = 1'b1;
    cyc();
    opera = 1'b0;
    cyc(3);
    check("mid_wb_we", 64'(rf_we), 64'(1));
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc();
    check("after_reset", 64'({rf_we, busy, instr_addr}), 64'(0));
`else
    we_cnt = 0;
    opera = 1'b1;
    cyc();
    opera = 1'b0;
    cyc(6);
    check("step1", 64'({busy, instr_addr, 8'(we_cnt)}), 64'({1'b0, 5'd1, 8'd1}));
    opera = 1'b1;
    cyc();
    opera = 1'b0;
    cyc(7);
    check("step2", 64'({busy, instr_addr, 8'(we_cnt)}), 64'({1'b0, 5'd2, 8'd2}));
    check("step_regs", 64'({rf[1], rf[2]}), 64'({32'd5, 32'd3}));
`endif
    for (int it = 0; it < 25; it++) begin
      do_reset($urandom_range(1, 3));
      for (int i = 0; i < 32; i++)
        rom[i] = enc(($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                     5'($urandom), 5'($urandom), 5'($urandom));
      hold = 1'($urandom_range(0, 1));
      for (int c = 0; c < 60; c++) begin
        opera = hold ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
        reset = $urandom_range(0, 49) == 0;
        cyc();
      end
    end
    reset = 1'b0;
    opera = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/calculadora_uc.md
# calculadora_uc

Control unit that sequences the calculator datapath (32-entry register file + add/sub ALU). It fetches 17-bit instructions from an external synchronous instruction ROM, decodes them, and drives register-file addresses, ALU op, write-data select and write enable. It runs a program when `opera` is asserted and reports completion on a HALT opcode. It sits beside the existing `calculadora` datapath, which it commands; the datapath keeps its `read`/`data` debug port.

## Interface
- `W`, 32, datapath width (passed through only for `imm` extension)
- `PCW`, 5, program counter width; ROM depth 2^PCW
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opera`  in  1  level start/run request, sampled in IDLE
- `instr_addr`  out  PCW  ROM address (= PC)
- `instr_data`  in  17  ROM data, valid 1 cycle after `instr_addr`
- `rf_ra1`, `rf_ra2`  out  5  register-file read addresses (rs1, rs2)
- `rf_wa`  out  5  write address (rd)
- `rf_we`  out  1  write enable
- `ula_op`  out  1  0 = add, 1 = sub
- `wd_sel`  out  1  0 = ALU result, 1 = `imm`
- `imm`  out  W  zero-extended `instr[4:0]`
- `busy`  out  1  high in any state except IDLE/STEP_WAIT
- `done`  out  1  one-cycle pulse on HALT

## Operation
- Instruction: `op[16:15]`, `rd[14:10]`, `rs1[9:5]`, `rs2/imm[4:0]`. Opcodes: 00 ADD (rd=rs1+rs2), 01 SUB (rd=rs1−rs2), 10 LDI (rd=imm), 11 HALT.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT (+ STEP_WAIT when configured).
- IDLE: `opera`=1 → FETCH; else stay.
- FETCH: `instr_addr`=PC → DECODE.
- DECODE: IR ← `instr_data`; HALT opcode → HALT, else → EXEC.
- EXEC: drive `rf_ra1`, `rf_ra2`, `rf_wa`, `ula_op`, `wd_sel`, `imm` from IR → WB.
- WB: same outputs held, `rf_we`=1, PC ← PC+1 (mod 2^PCW; 2^PCW−1 wraps to 0, no implicit halt) → FETCH.
- HALT: `done`=1 for this cycle, PC ← 0 → IDLE.
- LDI: `wd_sel`=1, `ula_op`=0; ADD/SUB: `wd_sel`=0. Outputs are Moore-decoded from state + IR; in IDLE/FETCH/DECODE/HALT `rf_we`=0 and the address/op outputs are 0.
- `rd`=0 is an ordinary register (no hard-wired zero).

## Timing
- Reset: state IDLE, PC=0, IR=0; all outputs 0. Reset in any state (including WB) forces `rf_we`=0 in the following cycle and aborts the instruction; PC is not incremented.
- Cycle t: IDLE, `opera`=1. t+1 FETCH, t+2 DECODE, t+3 EXEC, t+4 WB (write occurs on the t+4→t+5 edge), t+5 FETCH of next instruction. Each non-HALT instruction takes 4 cycles.
- HALT: DECODE at t+2, HALT with `done`=1 at t+3, IDLE at t+4.
- `opera` is ignored while `busy`=1. If it is still high when IDLE is re-entered, the program restarts from PC=0.
- `busy` rises in the cycle after `opera` is sampled. It is 0 in the HALT→IDLE cycle.

## Configuration
- `CALCULADORA_UC_STEP_EN` defined: single-step mode. WB → STEP_WAIT instead of FETCH. STEP_WAIT waits for `opera`=0, then goes to IDLE. The next `opera`=1 executes exactly one instruction, and PC is retained between steps. `busy`=0 in STEP_WAIT.
- Undefined: free-run until HALT; STEP_WAIT does not exist.

## Structure
- `calculadora_pkg`: opcode constants (OP_ADD, OP_SUB, OP_LDI, OP_HALT), state encoding typedef, INSTR_W=17 and field bit positions.
- One natural sub-module: `calculadora_uc_dec`, a combinational IR → (`ula_op`, `wd_sel`, `imm`, `is_halt`) decoder. The FSM and PC live in the top.

## Test plan
- Reset held 3 cycles mid-WB → `rf_we`=0, `busy`=0, `instr_addr`=0 the cycle after reset release.
- ROM[0]=LDI r1,5; ROM[1]=LDI r2,3; ROM[2]=SUB r3,r1,r2; ROM[3]=HALT; `opera`=1 for 1 cycle → three `rf_we` pulses, 4 cycles apart. Third pulse has `rf_wa`=3, `rf_ra1`=1, `rf_ra2`=2, `ula_op`=1. `done` pulses 15 cycles after `opera`; the datapath's r3 reads 2.
- ADD r4,r1,r1 with r1=5 → `wd_sel`=0, `ula_op`=0; r4 reads 10.
- PCW=2, ROM all LDI r1,7, no HALT → `instr_addr` sequence 0,1,2,3,0; `done` never asserts.
- `opera` held high with ROM[0]=HALT → `done` every 4 cycles, `busy` toggling 1,1,1,0.
- With `CALCULADORA_UC_STEP_EN`: program above, pulse `opera` twice → exactly two writes (r1=5, r2=3); PC=2; `busy`=0 between pulses.
